// File: rtl/alu_rs_pkg.sv
// Shared widths, free-value constants, opcode codes and entry layout for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned RS_SIZE = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NAME_W  = 5;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [TAG_W-1:0]  TAG_FREE  = '1;
  localparam logic [DATA_W-1:0] DATA_FREE = '0;
  localparam logic [NAME_W-1:0] NAME_FREE = '0;
  localparam logic [ADDR_W-1:0] ADDR_FREE = '0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_AND = 5'd3,
    OP_OR  = 5'd4,
    OP_XOR = 5'd5,
    OP_SLL = 5'd6,
    OP_SRL = 5'd7
  } op_e;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag_o;
    logic [TAG_W-1:0]  tag_t;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] data_t;
    logic [TAG_W-1:0]  wrt_tag;
    logic [NAME_W-1:0] wrt_name;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '{
    busy: 1'b0, op: OP_NOP, tag_o: TAG_FREE, tag_t: TAG_FREE,
    data_o: DATA_FREE, data_t: DATA_FREE, wrt_tag: TAG_FREE,
    wrt_name: NAME_FREE, addr: ADDR_FREE
  };

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  // Match one operand tag against both result buses; ALU bus has priority, free tag never matches.
  function automatic snoop_t snoop(
    input logic [TAG_W-1:0]  tag,
    input logic              en_a,
    input logic [TAG_W-1:0]  tag_a,
    input logic [DATA_W-1:0] data_a,
    input logic              en_l,
    input logic [TAG_W-1:0]  tag_l,
    input logic [DATA_W-1:0] data_l
  );
    snoop_t r;
    r.hit  = 1'b0;
    r.data = DATA_FREE;
    if (tag != TAG_FREE) begin
      if (en_a && (tag_a == tag)) begin
        r.hit  = 1'b1;
        r.data = data_a;
      end else if (en_l && (tag_l == tag)) begin
        r.hit  = 1'b1;
        r.data = data_l;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// 8-bit lowest-index priority encoder: found flag plus index of the lowest set request bit.
module alu_rs_pick
  import alu_rs_pkg::*;
(
  input  logic [RS_SIZE-1:0] req,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    for (int unsigned i = RS_SIZE; i > 0; i--) begin
      if (req[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: 8 entries, operand wake-up from two result buses, in-index-order issue.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inValid,
  input  logic [OP_W-1:0]   inOp,
  input  logic [TAG_W-1:0]  inTagO,
  input  logic [TAG_W-1:0]  inTagT,
  input  logic [DATA_W-1:0] inDataO,
  input  logic [DATA_W-1:0] inDataT,
  input  logic [TAG_W-1:0]  inWrtTag,
  input  logic [NAME_W-1:0] inWrtName,
  input  logic [ADDR_W-1:0] inAddr,
  input  logic              enALU,
  input  logic [TAG_W-1:0]  tagALU,
  input  logic [DATA_W-1:0] dataALU,
  input  logic              enLS,
  input  logic [TAG_W-1:0]  tagLS,
  input  logic [DATA_W-1:0] dataLS,
  output logic              full,
  output logic              ALUworkEn,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [NAME_W-1:0] wrtName,
  output logic [OP_W-1:0]   opCode,
  output logic [ADDR_W-1:0] instAddr
);

  entry_t             rs [RS_SIZE];
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  snoop_t             snp_o [RS_SIZE];
  snoop_t             snp_t [RS_SIZE];
  snoop_t             in_o;
  snoop_t             in_t;
  entry_t             new_entry;
  logic               free_found;
  logic               rdy_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = rs[i].busy;
      ready_vec[i] = rs[i].busy && (rs[i].tag_o == TAG_FREE) && (rs[i].tag_t == TAG_FREE);
      snp_o[i]     = snoop(rs[i].tag_o, enALU, tagALU, dataALU, enLS, tagLS, dataLS);
      snp_t[i]     = snoop(rs[i].tag_t, enALU, tagALU, dataALU, enLS, tagLS, dataLS);
    end
  end

  assign full = &busy_vec;

  // Incoming operands are bypassed from a same-cycle broadcast so they need not wait a further edge.
  always_comb begin
    in_o               = snoop(inTagO, enALU, tagALU, dataALU, enLS, tagLS, dataLS);
    in_t               = snoop(inTagT, enALU, tagALU, dataALU, enLS, tagLS, dataLS);
    new_entry.busy     = 1'b1;
    new_entry.op       = inOp;
    new_entry.tag_o    = in_o.hit ? TAG_FREE : inTagO;
    new_entry.tag_t    = in_t.hit ? TAG_FREE : inTagT;
    new_entry.data_o   = in_o.hit ? in_o.data : inDataO;
    new_entry.data_t   = in_t.hit ? in_t.data : inDataT;
    new_entry.wrt_tag  = inWrtTag;
    new_entry.wrt_name = inWrtName;
    new_entry.addr     = inAddr;
  end

  alu_rs_pick u_pick_free (
    .req   (~busy_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_rs_pick u_pick_ready (
    .req   (ready_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) rs[i] <= ENTRY_EMPTY;
      ALUworkEn <= 1'b0;
      operandO  <= DATA_FREE;
      operandT  <= DATA_FREE;
      wrtTag    <= TAG_FREE;
      wrtName   <= NAME_FREE;
      opCode    <= OP_NOP;
      instAddr  <= ADDR_FREE;
    end else if (clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) rs[i] <= ENTRY_EMPTY;
      ALUworkEn <= 1'b0;
      operandO  <= DATA_FREE;
      operandT  <= DATA_FREE;
      wrtTag    <= TAG_FREE;
      wrtName   <= NAME_FREE;
      opCode    <= OP_NOP;
      instAddr  <= ADDR_FREE;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (rs[i].busy) begin
          if (snp_o[i].hit) begin
            rs[i].tag_o  <= TAG_FREE;
            rs[i].data_o <= snp_o[i].data;
          end
          if (snp_t[i].hit) begin
            rs[i].tag_t  <= TAG_FREE;
            rs[i].data_t <= snp_t[i].data;
          end
        end
      end
      if (rdy_found) begin
        ALUworkEn          <= 1'b1;
        operandO           <= rs[rdy_idx].data_o;
        operandT           <= rs[rdy_idx].data_t;
        wrtTag             <= rs[rdy_idx].wrt_tag;
        wrtName            <= rs[rdy_idx].wrt_name;
        opCode             <= rs[rdy_idx].op;
        instAddr           <= rs[rdy_idx].addr;
        rs[rdy_idx].busy   <= 1'b0;
      end else begin
        ALUworkEn <= 1'b0;
        operandO  <= DATA_FREE;
        operandT  <= DATA_FREE;
        wrtTag    <= TAG_FREE;
        wrtName   <= NAME_FREE;
        opCode    <= OP_NOP;
        instAddr  <= ADDR_FREE;
      end
      // Free slot is chosen from pre-edge busy bits, so a slot issued this edge is not reused until next cycle.
      if (inValid && free_found) rs[free_idx] <= new_entry;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: single-entry vector table plus multi-cycle wake-up, full, clear and reset sequences.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        inValid;
  logic [4:0]  inOp;
  logic [3:0]  inTagO, inTagT;
  logic [31:0] inDataO, inDataT;
  logic [3:0]  inWrtTag;
  logic [4:0]  inWrtName;
  logic [31:0] inAddr;
  logic        enALU;
  logic [3:0]  tagALU;
  logic [31:0] dataALU;
  logic        enLS;
  logic [3:0]  tagLS;
  logic [31:0] dataLS;
  logic        full;
  logic        ALUworkEn;
  logic [31:0] operandO, operandT;
  logic [3:0]  wrtTag;
  logic [4:0]  wrtName;
  logic [4:0]  opCode;
  logic [31:0] instAddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst(rst), .clear(clear), .inValid(inValid), .inOp(inOp),
    .inTagO(inTagO), .inTagT(inTagT), .inDataO(inDataO), .inDataT(inDataT),
    .inWrtTag(inWrtTag), .inWrtName(inWrtName), .inAddr(inAddr),
    .enALU(enALU), .tagALU(tagALU), .dataALU(dataALU),
    .enLS(enLS), .tagLS(tagLS), .dataLS(dataLS),
    .full(full), .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT),
    .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode), .instAddr(instAddr)
  );

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  tag_o, tag_t;
    logic [31:0] d_o, d_t;
    logic [3:0]  wtag;
    logic [4:0]  name;
    logic [31:0] addr;
    logic        en_a;
    logic [3:0]  t_a;
    logic [31:0] d_a;
    logic        en_l;
    logic [3:0]  t_l;
    logic [31:0] d_l;
    logic [31:0] exp_o, exp_t;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    enALU = 1'b0; tagALU = 4'hF; dataALU = '0;
    enLS  = 1'b0; tagLS  = 4'hF; dataLS  = '0;
  endtask

  task automatic in_idle();
    inValid = 1'b0; inOp = '0; inTagO = 4'hF; inTagT = 4'hF;
    inDataO = '0; inDataT = '0; inWrtTag = 4'hF; inWrtName = '0; inAddr = '0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] t_o, input logic [3:0] t_t,
                       input logic [31:0] d_o, input logic [31:0] d_t, input logic [4:0] name);
    inValid = 1'b1; inOp = op; inTagO = t_o; inTagT = t_t;
    inDataO = d_o; inDataT = d_t; inWrtTag = 4'h4; inWrtName = name; inAddr = 32'h1000 + 32'(name);
  endtask

  task automatic chk_free(input string nm);
    chk({nm, ".en"},   32'(ALUworkEn), 32'd0);
    chk({nm, ".opO"},  operandO, 32'd0);
    chk({nm, ".tag"},  32'(wrtTag), 32'hF);
    chk({nm, ".op"},   32'(opCode), 32'd0);
    chk({nm, ".addr"}, instAddr, 32'd0);
  endtask

  initial begin
    vecs[0] = '{5'd1, 4'hF, 4'hF, 32'd5,      32'd7, 4'h1, 5'd3,  32'h100, 1'b0, 4'hF, 32'h0,   1'b0, 4'hF, 32'h0,   32'd5,     32'd7};
    vecs[1] = '{5'd2, 4'h3, 4'hF, 32'hDEAD,   32'd9, 4'h2, 5'd10, 32'h104, 1'b1, 4'h3, 32'h10,  1'b0, 4'hF, 32'h0,   32'h10,    32'd9};
    vecs[2] = '{5'd3, 4'hF, 4'h6, 32'd1,      32'd0, 4'h3, 5'd11, 32'h108, 1'b0, 4'hF, 32'h0,   1'b1, 4'h6, 32'hAB,  32'd1,     32'hAB};
    vecs[3] = '{5'd4, 4'h8, 4'h8, 32'd0,      32'd0, 4'h5, 5'd12, 32'h10C, 1'b1, 4'h8, 32'h111, 1'b1, 4'h8, 32'h222, 32'h111,   32'h111};
    vecs[4] = '{5'd5, 4'hF, 4'hF, 32'h33,     32'h44, 4'h6, 5'd13, 32'h110, 1'b1, 4'hF, 32'h99, 1'b1, 4'hF, 32'h77,  32'h33,    32'h44};
    vecs[5] = '{5'd6, 4'h2, 4'h5, 32'h1,      32'h2, 4'h7, 5'd31, 32'hFFFF_FFFC, 1'b1, 4'h2, 32'hA1, 1'b1, 4'h5, 32'hB2, 32'hA1, 32'hB2};

    rst = 1'b0; clear = 1'b0;
    in_idle(); bus_idle();
    step(); step();
    chk_free("reset");
    chk("reset.full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Table: one dispatch, optional same-cycle bypass, issue exactly one edge later.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].op, vecs[i].tag_o, vecs[i].tag_t, vecs[i].d_o, vecs[i].d_t, vecs[i].name);
      inWrtTag = vecs[i].wtag; inAddr = vecs[i].addr;
      enALU = vecs[i].en_a; tagALU = vecs[i].t_a; dataALU = vecs[i].d_a;
      enLS  = vecs[i].en_l; tagLS  = vecs[i].t_l; dataLS  = vecs[i].d_l;
      step();
      in_idle(); bus_idle();
      chk($sformatf("v%0d.en0", i), 32'(ALUworkEn), 32'd0);
      step();
      chk($sformatf("v%0d.en1", i),  32'(ALUworkEn), 32'd1);
      chk($sformatf("v%0d.opO", i),  operandO, vecs[i].exp_o);
      chk($sformatf("v%0d.opT", i),  operandT, vecs[i].exp_t);
      chk($sformatf("v%0d.code", i), 32'(opCode), 32'(vecs[i].op));
      chk($sformatf("v%0d.wtag", i), 32'(wrtTag), 32'(vecs[i].wtag));
      chk($sformatf("v%0d.name", i), 32'(wrtName), 32'(vecs[i].name));
      chk($sformatf("v%0d.addr", i), instAddr, vecs[i].addr);
      step();
      chk($sformatf("v%0d.en2", i), 32'(ALUworkEn), 32'd0);
      chk($sformatf("v%0d.full", i), 32'(full), 32'd0);
    end

    // Late wake-up: issue exactly one edge after the capture edge.
    drive(5'd1, 4'h3, 4'hF, 32'h0, 32'h22, 5'd7);
    step(); in_idle();
    for (int i = 0; i < 3; i++) begin
      chk("wake.wait", 32'(ALUworkEn), 32'd0);
      step();
    end
    enALU = 1'b1; tagALU = 4'h3; dataALU = 32'h10;
    step(); bus_idle();
    chk("wake.cap", 32'(ALUworkEn), 32'd0);
    step();
    chk("wake.en",  32'(ALUworkEn), 32'd1);
    chk("wake.opO", operandO, 32'h10);
    chk("wake.opT", operandT, 32'h22);
    step();

    // Fill all entries on tag 2, drop a ninth dispatch, then drain in index order.
    for (int i = 0; i < 8; i++) begin
      chk("fill.full_lo", 32'(full), 32'd0);
      drive(5'd2, 4'h2, 4'hF, 32'h0, 32'(i), 5'(i));
      step();
    end
    in_idle();
    chk("fill.full", 32'(full), 32'd1);
    drive(5'd1, 4'hF, 4'hF, 32'h9, 32'h9, 5'd30);
    step(); in_idle();
    chk("fill.drop_en", 32'(ALUworkEn), 32'd0);
    chk("fill.full2",   32'(full), 32'd1);
    enLS = 1'b1; tagLS = 4'h2; dataLS = 32'h55;
    step(); bus_idle();
    chk("fill.cap_en", 32'(ALUworkEn), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d.en", i),   32'(ALUworkEn), 32'd1);
      chk($sformatf("drain%0d.name", i), 32'(wrtName), 32'(i));
      chk($sformatf("drain%0d.opT", i),  operandT, 32'(i));
      chk($sformatf("drain%0d.opO", i),  operandO, 32'h55);
    end
    step();
    chk("drain.after", 32'(ALUworkEn), 32'd0);
    chk("drain.full",  32'(full), 32'd0);

    // Flush: 3 waiting + 1 ready (would issue at the clear edge) plus concurrent dispatch and snoop.
    for (int i = 0; i < 3; i++) begin
      drive(5'd3, 4'h7, 4'hF, 32'h0, 32'h0, 5'(20 + i));
      step();
    end
    drive(5'd3, 4'hF, 4'hF, 32'h1, 32'h1, 5'd23);
    step();
    clear = 1'b1;
    drive(5'd1, 4'hF, 4'hF, 32'h2, 32'h2, 5'd24);
    enALU = 1'b1; tagALU = 4'h7; dataALU = 32'h77;
    step();
    clear = 1'b0; in_idle(); bus_idle();
    chk("clr.full", 32'(full), 32'd0);
    chk_free("clr");
    enALU = 1'b1; tagALU = 4'h7; dataALU = 32'h77;
    step(); bus_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr.noissue", 32'(ALUworkEn), 32'd0);
    end

    // Asynchronous reset between edges while an issue is visible.
    drive(5'd4, 4'h9, 4'hF, 32'h0, 32'h0, 5'd17);
    step();
    drive(5'd1, 4'hF, 4'hF, 32'h1, 32'h2, 5'd18);
    step(); in_idle();
    step();
    chk("arst.pre_en", 32'(ALUworkEn), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_free("arst");
    chk("arst.full", 32'(full), 32'd0);
    #1 rst = 1'b1;
    drive(5'd5, 4'hF, 4'hF, 32'h3, 32'h4, 5'd19);
    enALU = 1'b1; tagALU = 4'h9; dataALU = 32'h99;
    step(); in_idle(); bus_idle();
    chk("arst.first_en0", 32'(ALUworkEn), 32'd0);
    step();
    chk("arst.first_en",   32'(ALUworkEn), 32'd1);
    chk("arst.first_name", 32'(wrtName), 32'd19);
    chk("arst.first_opO",  operandO, 32'h3);
    step();
    chk("arst.flushed", 32'(ALUworkEn), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 clear  in  1  synchronous flush (mispredict), active-high.
REQ-004 inValid  in  1  dispatch request; inOp in 5, inTagO/inTagT in 4, inDataO/inDataT in 32, inWrtTag in 4, inWrtName in 5, inAddr in 32.
REQ-005 enALU/tagALU/dataALU  in  1/4/32  ALU broadcast bus; enLS/tagLS/dataLS  in  1/4/32  load-store broadcast bus.
REQ-006 full  out  1  all entries busy; dispatcher stalls.
REQ-007 ALUworkEn  out  1  issue valid; operandO/operandT out 32, wrtTag out 4, wrtName out 5, opCode out 5, instAddr out 32, all registered.

Function
REQ-008 The block SHALL hold RS_SIZE = 8 entries: busy, op, tagO, tagT, dataO, dataT, wrtTag, wrtName, addr.
REQ-009 An operand SHALL be ready when its tag equals tagFree (4'b1111); the operand data is then valid.
REQ-010 Dispatch: if inValid and not full and not clear, the lowest-index non-busy entry SHALL be written busy at the edge.
REQ-011 Dispatch bypass: an incoming operand whose tag matches an asserted broadcast the same cycle SHALL be stored with the broadcast data and tagFree.
REQ-012 Snoop: for every busy entry, an operand tag equal to an asserted broadcast tag SHALL capture that data and become tagFree at the edge.
REQ-013 Broadcast tag equal to tagFree SHALL be ignored; if both buses carry the same tag, ALU data wins.
REQ-014 Issue: at each edge the lowest-index busy entry with both operands ready (pre-edge state) SHALL be copied to the output registers with ALUworkEn=1 and cleared non-busy.
REQ-015 If no entry is ready, ALUworkEn SHALL be 0 and other outputs SHALL take free values (dataFree=0, tagFree, nameFree=0, opcode 0, addrFree=0).
REQ-016 Latency: entry dispatched ready at edge k SHALL issue at edge k+1; operand woken at edge k SHALL make its entry eligible at edge k+1.
REQ-017 At most one issue and one dispatch per cycle; an entry freed by issue SHALL be reusable from the next cycle only.
REQ-018 full SHALL be combinational from state: 1 iff all 8 entries busy; dispatch while full SHALL be dropped with no state change.
REQ-019 clear SHALL invalidate all entries and force ALUworkEn=0 at that edge; simultaneous dispatch and snoop SHALL be discarded.
REQ-020 Issue order among ready entries SHALL be strictly by index, not by age.

Reset
REQ-021 While rst=0 all entries SHALL be non-busy, tags tagFree, data 0; ALUworkEn=0, outputs at free values, full=0.
REQ-022 Reset asserted mid-operation SHALL discard all pending entries immediately, independent of clk.
REQ-023 First dispatch SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-024 RS_SIZE, tagFree, dataFree, nameFree, addrFree, bus widths and opcode codes SHALL live in the shared defines header.
REQ-025 One sub-module alu_rs_pick (8-bit lowest-index priority encoder, found flag + 3-bit index) SHALL be instantiated twice: free slot and ready slot.
REQ-026 No arithmetic SHALL be performed in this block; operands pass through unchanged.

Verification
REQ-027 Dispatch ADD with both tags tagFree, data 5 and 7 -> next cycle ALUworkEn=1, operandO=5, operandT=7, opCode=ADD, entry freed.
REQ-028 Dispatch with tagO=3 pending; later enALU=1, tagALU=3, dataALU=0x10 -> operandO captured 0x10, issue exactly one edge after capture.
REQ-029 Dispatch tagT=6 same cycle as enLS=1, tagLS=6, dataLS=0xAB -> stored ready via bypass, issues next edge with operandT=0xAB.
REQ-030 Fill 8 entries all waiting on tag 2 -> full=1, ninth dispatch dropped; broadcast tag 2 -> entries issue in index order 0..7 on 8 consecutive edges.
REQ-031 clear asserted with 4 busy entries plus a concurrent dispatch -> next cycle full=0, ALUworkEn=0, no later issue of any flushed entry.
REQ-032 rst pulled low between edges with ALUworkEn=1 -> outputs go to free values immediately, all entries empty after release.
